frame_capture_ctrl: RTL and testbench

Sequences capture of frames from the parallel camera interface (pixel, vsync high for the whole frame, hsync high during active pixels) into a downstream pixel stream. Arms on request and aligns to the next full frame; never emits a partial frame. Tracks row/column position against configured dimensions and tags the stream with start-of-frame/end-of-line/end-of-frame. Reports per-frame line/frame length errors. Sits between the camera pins (after the clock-domain boundary) and the frame buffer writer.

---
 rtl/frame_capture_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_frame_capture_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture_ctrl.sv
// Frame capture sequencer: arms on request, aligns to the next full camera frame and
// emits a tagged pixel stream. Define CAPTURE_CROP_EN to emit only a crop window.
module frame_capture_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIM_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] cam_pixel_i,
    input  logic             cam_vsync_i,
    input  logic             cam_hsync_i,
    input  logic [DIM_W-1:0] cfg_cols_i,
    input  logic [DIM_W-1:0] cfg_rows_i,
    input  logic [DIM_W-1:0] crop_x0_i,
    input  logic [DIM_W-1:0] crop_y0_i,
    input  logic [DIM_W-1:0] crop_w_i,
    input  logic [DIM_W-1:0] crop_h_i,
    input  logic             cap_req_i,
    input  logic             cap_cont_i,
    input  logic             cap_abort_i,
    output logic             cap_ack_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    output logic             out_sof_o,
    output logic             out_eol_o,
    output logic             out_eof_o,
    output logic             frame_done_o,
    output logic             err_line_o,
    output logic             err_frame_o,
    output logic             err_cfg_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [DIM_W-1:0] DIM_MAX = '1;

    function automatic logic [DIM_W-1:0] sat_inc(input logic [DIM_W-1:0] v);
        return (v == DIM_MAX) ? v : v + DIM_W'(1);
    endfunction

    // p0: camera sample stage, p1: history stage for edge detect
    logic             s_vsync_p0_q, s_hsync_p0_q;
    logic             h_vsync_p1_q, h_hsync_p1_q;
    logic [WIDTH-1:0] s_pixel_p0_q, h_pixel_p1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_vsync_p0_q <= 1'b0;
            s_hsync_p0_q <= 1'b0;
            h_vsync_p1_q <= 1'b0;
            h_hsync_p1_q <= 1'b0;
        end else begin
            s_vsync_p0_q <= cam_vsync_i;
            s_hsync_p0_q <= cam_hsync_i;
            h_vsync_p1_q <= s_vsync_p0_q;
            h_hsync_p1_q <= s_hsync_p0_q;
        end
    end

    always_ff @(posedge clk) begin
        s_pixel_p0_q <= cam_pixel_i;
        h_pixel_p1_q <= s_pixel_p0_q;
    end

    logic vs_rise, vs_fall, hs_fall;
    assign vs_rise = s_vsync_p0_q & ~h_vsync_p1_q;
    assign vs_fall = ~s_vsync_p0_q & h_vsync_p1_q;
    assign hs_fall = ~s_hsync_p0_q & h_hsync_p1_q;

    // Configuration check and emission window derived from the request-time inputs
    logic             cfg_ok;
    logic [DIM_W-1:0] win_x0_new, win_x1_new, win_y0_new, win_y1_new;

`ifdef CAPTURE_CROP_EN
    logic [DIM_W:0] crop_x_end, crop_y_end;
    assign crop_x_end = {1'b0, crop_x0_i} + {1'b0, crop_w_i};
    assign crop_y_end = {1'b0, crop_y0_i} + {1'b0, crop_h_i};
    assign cfg_ok = (cfg_cols_i != '0) && (cfg_rows_i != '0) &&
                    (crop_w_i != '0) && (crop_h_i != '0) &&
                    (crop_x_end <= {1'b0, cfg_cols_i}) &&
                    (crop_y_end <= {1'b0, cfg_rows_i});
    assign win_x0_new = crop_x0_i;
    assign win_y0_new = crop_y0_i;
    assign win_x1_new = crop_x0_i + crop_w_i - DIM_W'(1);
    assign win_y1_new = crop_y0_i + crop_h_i - DIM_W'(1);
`else
    logic unused_crop;
    assign unused_crop = ^{crop_x0_i, crop_y0_i, crop_w_i, crop_h_i};
    assign cfg_ok = (cfg_cols_i != '0) && (cfg_rows_i != '0);
    assign win_x0_new = '0;
    assign win_y0_new = '0;
    assign win_x1_new = cfg_cols_i - DIM_W'(1);
    assign win_y1_new = cfg_rows_i - DIM_W'(1);
`endif

    logic [1:0]       state_q, state_d;
    logic [DIM_W-1:0] col_q, col_d, row_q, row_d;
    logic [DIM_W-1:0] cols_q, cols_d, rows_q, rows_d;
    logic [DIM_W-1:0] win_x0_q, win_x0_d, win_x1_q, win_x1_d;
    logic [DIM_W-1:0] win_y0_q, win_y0_d, win_y1_q, win_y1_d;
    logic             cap_ack_q, cap_ack_d, frame_done_q, frame_done_d;
    logic             out_valid_q, out_valid_d, out_sof_q, out_sof_d;
    logic             out_eol_q, out_eol_d, out_eof_q, out_eof_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             err_line_q, err_line_d, err_frame_q, err_frame_d;
    logic             err_cfg_q, err_cfg_d;
    logic [DIM_W-1:0] col_v, row_v;
    logic             in_win;

    assign in_win = (col_q >= win_x0_q) && (col_q <= win_x1_q) &&
                    (row_q >= win_y0_q) && (row_q <= win_y1_q);

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        cols_d       = cols_q;
        rows_d       = rows_q;
        win_x0_d     = win_x0_q;
        win_x1_d     = win_x1_q;
        win_y0_d     = win_y0_q;
        win_y1_d     = win_y1_q;
        cap_ack_d    = 1'b0;
        frame_done_d = 1'b0;
        out_valid_d  = 1'b0;
        out_sof_d    = 1'b0;
        out_eol_d    = 1'b0;
        out_eof_d    = 1'b0;
        out_data_d   = out_data_q;
        err_line_d   = err_line_q;
        err_frame_d  = err_frame_q;
        err_cfg_d    = err_cfg_q;
        col_v        = col_q;
        row_v        = row_q;

        case (state_q)
            S_IDLE: begin
                if (cap_req_i && !cap_abort_i) begin
                    if (cfg_ok) begin
                        cap_ack_d   = 1'b1;
                        cols_d      = cfg_cols_i;
                        rows_d      = cfg_rows_i;
                        win_x0_d    = win_x0_new;
                        win_x1_d    = win_x1_new;
                        win_y0_d    = win_y0_new;
                        win_y1_d    = win_y1_new;
                        err_line_d  = 1'b0;
                        err_frame_d = 1'b0;
                        err_cfg_d   = 1'b0;
                        state_d     = S_ARMED;
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            S_ARMED: begin
                if (cap_abort_i) begin
                    state_d = S_IDLE;
                end else if (vs_rise) begin
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (cap_abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (h_hsync_p1_q) begin
                        if (col_q >= cols_q) err_line_d = 1'b1;
                        if (row_q >= rows_q) err_frame_d = 1'b1;
                        if ((col_q < cols_q) && (row_q < rows_q) && in_win) begin
                            out_valid_d = 1'b1;
                            out_data_d  = h_pixel_p1_q;
                            out_sof_d   = (col_q == win_x0_q) && (row_q == win_y0_q);
                            out_eol_d   = (col_q == win_x1_q);
                            out_eof_d   = (col_q == win_x1_q) && (row_q == win_y1_q);
                        end
                        col_v = sat_inc(col_q);
                    end
                    // The line's last pixel and the hsync falling edge are handled in one cycle
                    if (hs_fall) begin
                        if (col_v != cols_q) err_line_d = 1'b1;
                        col_v = '0;
                        row_v = sat_inc(row_q);
                    end
                    if (vs_fall) begin
                        if (row_v != rows_q) err_frame_d = 1'b1;
                        state_d = S_DONE;
                    end
                    col_d = col_v;
                    row_d = row_v;
                end
            end
            default: begin
                frame_done_d = 1'b1;
                state_d      = cap_cont_i ? S_ARMED : S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            cols_q       <= '0;
            rows_q       <= '0;
            win_x0_q     <= '0;
            win_x1_q     <= '0;
            win_y0_q     <= '0;
            win_y1_q     <= '0;
            cap_ack_q    <= 1'b0;
            frame_done_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_sof_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            out_data_q   <= '0;
            err_line_q   <= 1'b0;
            err_frame_q  <= 1'b0;
            err_cfg_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            cols_q       <= cols_d;
            rows_q       <= rows_d;
            win_x0_q     <= win_x0_d;
            win_x1_q     <= win_x1_d;
            win_y0_q     <= win_y0_d;
            win_y1_q     <= win_y1_d;
            cap_ack_q    <= cap_ack_d;
            frame_done_q <= frame_done_d;
            out_valid_q  <= out_valid_d;
            out_sof_q    <= out_sof_d;
            out_eol_q    <= out_eol_d;
            out_eof_q    <= out_eof_d;
            out_data_q   <= out_data_d;
            err_line_q   <= err_line_d;
            err_frame_q  <= err_frame_d;
            err_cfg_q    <= err_cfg_d;
        end
    end

    assign cap_ack_o    = cap_ack_q;
    assign busy_o       = (state_q == S_ARMED) || (state_q == S_ACTIVE);
    assign out_data_o   = out_data_q;
    assign out_valid_o  = out_valid_q;
    assign out_sof_o    = out_sof_q;
    assign out_eol_o    = out_eol_q;
    assign out_eof_o    = out_eof_q;
    assign frame_done_o = frame_done_q;
    assign err_line_o   = err_line_q;
    assign err_frame_o  = err_frame_q;
    assign err_cfg_o    = err_cfg_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl: 8x4 frames driven on the camera pins, stream and
// status compared against hand-computed values.
module tb_frame_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  cam_pixel = 8'h00;
    logic        cam_vsync = 1'b0, cam_hsync = 1'b0;
    logic [11:0] cfg_cols = 12'd8, cfg_rows = 12'd4;
    logic [11:0] crop_x0 = '0, crop_y0 = '0, crop_w = '0, crop_h = '0;
    logic        cap_req = 1'b0, cap_cont = 1'b0, cap_abort = 1'b0;
    logic        cap_ack, busy, out_valid, out_sof, out_eol, out_eof, frame_done;
    logic        err_line, err_frame, err_cfg;
    logic [7:0]  out_data;

    int checks = 0;
    int errors = 0;
    int tick = 0;
    int fd_cnt = 0;
    int ack_cnt = 0;
    logic [10:0] beats[$];
    int          bticks[$];

    frame_capture_ctrl #(.WIDTH(8), .DIM_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .cam_pixel_i(cam_pixel), .cam_vsync_i(cam_vsync), .cam_hsync_i(cam_hsync),
        .cfg_cols_i(cfg_cols), .cfg_rows_i(cfg_rows),
        .crop_x0_i(crop_x0), .crop_y0_i(crop_y0), .crop_w_i(crop_w), .crop_h_i(crop_h),
        .cap_req_i(cap_req), .cap_cont_i(cap_cont), .cap_abort_i(cap_abort),
        .cap_ack_o(cap_ack), .busy_o(busy),
        .out_data_o(out_data), .out_valid_o(out_valid),
        .out_sof_o(out_sof), .out_eol_o(out_eol), .out_eof_o(out_eof),
        .frame_done_o(frame_done),
        .err_line_o(err_line), .err_frame_o(err_frame), .err_cfg_o(err_cfg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick <= tick + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            beats.push_back({out_sof, out_eol, out_eof, out_data});
            bticks.push_back(tick);
        end
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (cap_ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({cap_ack, busy, out_valid, out_sof, out_eol, out_eof, frame_done,
                    err_line, err_frame, err_cfg, out_data});
    endfunction

    // 8-column frame, pixel value {row, col}; long_row gets a 9th pixel
    task automatic send_frame(input int nrows, input int long_row, input int cont_off_row,
                              output int first_tick, output logic fd3);
        first_tick = 0;
        cam_vsync = 1'b1;
        cyc(); cyc();
        for (int r = 0; r < nrows; r++) begin
            if (r == cont_off_row) cap_cont = 1'b0;
            for (int c = 0; c < ((r == long_row) ? 9 : 8); c++) begin
                cam_hsync = 1'b1;
                cam_pixel = 8'(r * 16 + c);
                if (r == 0 && c == 0) first_tick = tick;
                cyc();
            end
            cam_hsync = 1'b0;
            cyc(); cyc();
        end
        cam_vsync = 1'b0;
        cyc(); cyc(); cyc();
        fd3 = frame_done;
        cyc();
    endtask

    task automatic request();
        cap_req = 1'b1;
        cyc();
        cap_req = 1'b0;
    endtask

    initial begin
        int   b0, f0, a0, ft;
        logic fd3;
        logic [10:0] e;

        cyc(); cyc();
        chk("reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;
        cyc();

        // clean 8x4 frame
        request();
        chk("ack_pulse", 32'(cap_ack), 32'd1);
        chk("busy_armed", 32'(busy), 32'd1);
        cyc();
        chk("ack_one_cycle", 32'(cap_ack), 32'd0);
        b0 = beats.size(); f0 = fd_cnt;
        send_frame(4, -1, -1, ft, fd3);
        chk("clean_count", 32'(beats.size() - b0), 32'd32);
        for (int k = 0; k < 32; k++) begin
            e = {k == 0, (k % 8) == 7, k == 31, 8'((k / 8) * 16 + (k % 8))};
            chk($sformatf("clean_beat%0d", k), 32'(beats[b0 + k]), 32'(e));
        end
        chk("latency", 32'(bticks[b0] - ft), 32'd3);
        chk("frame_done_at3", 32'(fd3), 32'd1);
        chk("clean_fd_count", 32'(fd_cnt - f0), 32'd1);
        chk("clean_errs", 32'({err_line, err_frame, err_cfg}), 32'd0);
        chk("clean_idle", 32'(busy), 32'd0);

        // arm while a frame is already in progress
        cam_vsync = 1'b1;
        cyc();
        cam_hsync = 1'b1; cam_pixel = 8'h55; cyc();
        request();
        chk("midarm_ack", 32'(cap_ack), 32'd1);
        b0 = beats.size(); f0 = fd_cnt;
        repeat (4) cyc();
        cam_hsync = 1'b0; cyc();
        cam_vsync = 1'b0; repeat (4) cyc();
        chk("midarm_no_out", 32'(beats.size() - b0), 32'd0);
        chk("midarm_no_fd", 32'(fd_cnt - f0), 32'd0);
        chk("midarm_still_busy", 32'(busy), 32'd1);
        send_frame(4, -1, -1, ft, fd3);
        chk("midarm_count", 32'(beats.size() - b0), 32'd32);
        chk("midarm_first", 32'(beats[b0]), 32'({3'b100, 8'h00}));
        chk("midarm_last", 32'(beats[b0 + 31]), 32'({3'b011, 8'h37}));

        // long row 1 and short frame
        request();
        cyc();
        b0 = beats.size(); f0 = fd_cnt;
        send_frame(3, 1, -1, ft, fd3);
        chk("err_count", 32'(beats.size() - b0), 32'd24);
        chk("err_row1_last", 32'(beats[b0 + 15]), 32'({3'b010, 8'h17}));
        chk("err_row2_first", 32'(beats[b0 + 16]), 32'({3'b000, 8'h20}));
        chk("err_last", 32'(beats[b0 + 23]), 32'({3'b010, 8'h27}));
        chk("err_line", 32'(err_line), 32'd1);
        chk("err_frame", 32'(err_frame), 32'd1);
        chk("err_fd", 32'(fd_cnt - f0), 32'd1);

        // continuous capture: three frames on one request
        cap_cont = 1'b1;
        a0 = ack_cnt;
        request();
        chk("cont_err_clear", 32'({err_line, err_frame}), 32'd0);
        cyc();
        b0 = beats.size(); f0 = fd_cnt;
        send_frame(4, -1, -1, ft, fd3);
        chk("cont_busy_f1", 32'(busy), 32'd1);
        send_frame(4, -1, -1, ft, fd3);
        send_frame(4, -1, 1, ft, fd3);
        chk("cont_fd", 32'(fd_cnt - f0), 32'd3);
        chk("cont_ack", 32'(ack_cnt - a0), 32'd1);
        chk("cont_beats", 32'(beats.size() - b0), 32'd96);
        chk("cont_idle", 32'(busy), 32'd0);

        // abort during row 1
        request();
        cyc();
        b0 = beats.size(); f0 = fd_cnt;
        cam_vsync = 1'b1; cyc(); cyc();
        for (int c = 0; c < 8; c++) begin
            cam_hsync = 1'b1; cam_pixel = 8'(c); cyc();
        end
        cam_hsync = 1'b0; cyc(); cyc();
        for (int c = 0; c < 2; c++) begin
            cam_hsync = 1'b1; cam_pixel = 8'(16 + c); cyc();
        end
        cam_pixel = 8'h12; cap_abort = 1'b1; cyc();
        cap_abort = 1'b0;
        chk("abort_valid_off", 32'(out_valid), 32'd0);
        chk("abort_not_busy", 32'(busy), 32'd0);
        for (int c = 3; c < 8; c++) begin
            cam_pixel = 8'(16 + c); cyc();
        end
        cam_hsync = 1'b0; cyc();
        cam_vsync = 1'b0; repeat (5) cyc();
        chk("abort_beats", 32'(beats.size() - b0), 32'd8);
        chk("abort_no_fd", 32'(fd_cnt - f0), 32'd0);

        // reset pulse mid-frame
        request();
        cyc();
        cam_vsync = 1'b1; cyc(); cyc();
        for (int c = 0; c < 5; c++) begin
            cam_hsync = 1'b1; cam_pixel = 8'(c); cyc();
        end
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_midframe", all_outs(), 32'd0);
        rst_n = 1'b1;
        cyc();
        b0 = beats.size();
        repeat (3) cyc();
        cam_hsync = 1'b0; cyc();
        cam_vsync = 1'b0; repeat (5) cyc();
        chk("post_reset_idle", 32'(busy), 32'd0);
        chk("post_reset_quiet", 32'(beats.size() - b0), 32'd0);

        // zero dimension rejected, then accepted config clears err_cfg
        cfg_rows = 12'd0;
        a0 = ack_cnt;
        request();
        chk("badcfg_err", 32'(err_cfg), 32'd1);
        chk("badcfg_idle", 32'(busy), 32'd0);
        cyc();
        chk("badcfg_no_ack", 32'(ack_cnt - a0), 32'd0);
        cfg_rows = 12'd4;
        request();
        chk("goodcfg_ack", 32'(cap_ack), 32'd1);
        chk("goodcfg_err_clr", 32'(err_cfg), 32'd0);
        cap_abort = 1'b1; cyc(); cap_abort = 1'b0;
        chk("armed_abort", 32'(busy), 32'd0);

`ifdef CAPTURE_CROP_EN
        crop_x0 = 12'd2; crop_y0 = 12'd1; crop_w = 12'd3; crop_h = 12'd2;
        request();
        cyc();
        b0 = beats.size();
        send_frame(4, -1, -1, ft, fd3);
        chk("crop_count", 32'(beats.size() - b0), 32'd6);
        chk("crop_b0", 32'(beats[b0 + 0]), 32'({3'b100, 8'h12}));
        chk("crop_b1", 32'(beats[b0 + 1]), 32'({3'b000, 8'h13}));
        chk("crop_b2", 32'(beats[b0 + 2]), 32'({3'b010, 8'h14}));
        chk("crop_b3", 32'(beats[b0 + 3]), 32'({3'b000, 8'h22}));
        chk("crop_b4", 32'(beats[b0 + 4]), 32'({3'b000, 8'h23}));
        chk("crop_b5", 32'(beats[b0 + 5]), 32'({3'b011, 8'h24}));
        crop_x0 = 12'd6; crop_y0 = 12'd0; crop_w = 12'd3; crop_h = 12'd1;
        a0 = ack_cnt;
        request();
        chk("crop_bad_err", 32'(err_cfg), 32'd1);
        cyc();
        chk("crop_bad_no_ack", 32'(ack_cnt - a0), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
